axil_pr_decouple_guard: RTL and testbench
=========================================

Name: axil_pr_decouple_guard

Overview:
- Sits between the shell's AXI-Lite control master (M_AXI_LITE_TO_HLS_PR_NORTH) and the HLS kernel inside the north PR region.
- Forwards register reads and writes to the PR region while it is coupled.
- While decoupled (during partial reconfiguration), or when the PR slave hangs, completes every transaction locally with SLVERR so the PCIe host never stalls.
- Counts timeouts for host diagnostics.

Parameters:
- ADDR_W, 32, AXI-Lite address width
- DATA_W, 32, AXI-Lite data width (32 only; wstrb = DATA_W/8)
- TIMEOUT_CYCLES, 4096, cycles a forwarded transaction may wait for its downstream response (must be ≥ 2)
- CNT_W, 16, width of the saturating timeout counter

Ports:
- sys_clk  in  1  single clock; all logic on its rising edge
- sys_rst  in  1  synchronous, active-high reset
- s_axil_aw{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_W/3  upstream write address
- s_axil_w{valid,ready,data,strb}  in/out/in/in  1/1/DATA_W/DATA_W/8  upstream write data
- s_axil_b{valid,ready,resp}  out/in/out  1/1/2  upstream write response
- s_axil_ar{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_W/3  upstream read address
- s_axil_r{valid,ready,data,resp}  out/in/out/out  1/1/DATA_W/2  upstream read data
- m_axil_*  mirror of s_axil_* with directions reversed  downstream to the PR region
- decouple_req  in  1  request isolation of the PR region
- decouple_ack  out  1  isolation is in effect
- timeout_pulse  out  1  one-cycle pulse on each timeout
- timeout_count  out  CNT_W  saturating count of timeouts

Behaviour:
Interface (decided): single clock sys_clk; reset sys_rst is synchronous and active-high.

Reset:
- All valid and ready outputs 0, decouple_ack 0, timeout_count 0, both FSMs in IDLE.
- m_axil address and data outputs are registered and reset to 0.
- A reset asserted mid-transaction abandons the transaction silently; no response is issued.

Write FSM (states W_IDLE, W_ISSUE, W_WAIT, W_RESP, W_DRAIN):
- W_IDLE:
  - s_axil_awready and s_axil_wready are 1 until the matching beat is captured (each channel independently).
  - Once both AW and W are held: if decouple_ack=1, go to W_RESP with bresp=2'b10. Otherwise go to W_ISSUE.
- W_ISSUE:
  - Drive m_axil_awvalid and m_axil_wvalid from registers; each drops on its own handshake.
  - When both have completed, go to W_WAIT. The timer loads 0 on entry to W_ISSUE.
- W_WAIT:
  - m_axil_bready=1.
  - On m_axil_bvalid, capture bresp and go to W_RESP.
  - If the timer reaches TIMEOUT_CYCLES-1 with no response, set bresp=2'b10, pulse timeout_pulse, and go to W_RESP with orphan flag set.
  - The timer runs through W_ISSUE and W_WAIT; a stuck AWREADY/WREADY also times out. In that case m_axil_*valid are held until accepted (AXI rule).
- W_RESP:
  - s_axil_bvalid=1 with held bresp until s_axil_bready.
  - Then go to W_DRAIN if orphan, else W_IDLE.
- W_DRAIN:
  - Keep m_axil_bready=1 and finish any pending AW/W handshakes.
  - Leave on m_axil_bvalid, or immediately if decouple_ack=1.
  - No new upstream write is accepted in this state.

Read FSM (R_IDLE, R_ISSUE, R_WAIT, R_RESP, R_DRAIN):
- Identical structure to the write FSM.
- Local error response: rdata=32'hDEC0_DEAD, rresp=2'b10.
- Downstream rdata and rresp are captured and held while s_axil_rvalid is high.

Concurrency:
- The read and write paths are independent; at most one outstanding transaction per direction.
- Simultaneous timeouts on both paths in the same cycle: timeout_pulse=1 for one cycle and timeout_count increments by 2, saturating at all-ones.

Decoupling:
- decouple_ack changes only in a cycle where both FSMs are IDLE. It follows decouple_req one cycle after both FSMs are idle and the levels differ.
- While decouple_ack=1, all m_axil_*valid and m_axil_*ready outputs are 0.
- Decoupled transactions complete with at most 2-cycle latency (capture cycle, then response) and do not increment timeout_count.

Latency (coupled path):
- AW/W capture to m_axil valid: 1 cycle.
- Downstream response capture to s_axil valid: 1 cycle.

Decomposition:
- Package axil_pr_pkg holds:
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - DECOUPLE_RDATA=32'hDEC0_DEAD
  - state enums wr_state_t and rd_state_t
- One sub-module is natural: axil_pr_timeout_ctr, a load/enable/expire counter sized by $clog2(TIMEOUT_CYCLES). It is instantiated twice, once per direction.

Test Plan:
- Coupled write 0x10 ← 0xCAFEF00D, slave responds OKAY after 5 cycles → m_axil_awaddr=0x10 and wdata match; s_axil_bresp=00; timeout_count=0.
- Coupled read 0x20, slave returns 0x12345678 → s_axil_rdata=0x12345678, rresp=00, s_axil_rvalid 1 cycle after m_axil_rvalid.
- Silent slave, TIMEOUT_CYCLES=16: a read is issued → s_axil_rresp=10 and rdata=0xDEC0DEAD exactly 16 cycles after ARREADY; timeout_pulse=1; count=1. A late m_axil_rvalid 30 cycles later is drained and not forwarded upstream.
- decouple_req raised while a write is in W_WAIT → decouple_ack stays 0 until the write completes, then rises. A following write gets bresp=10 within 2 cycles with no m_axil activity.
- Simultaneous timeouts with timeout_count at 0xFFFE → count=0xFFFF and it stays saturated on further timeouts.
- sys_rst asserted for 1 cycle mid-R_WAIT → all valid outputs 0 the next cycle, FSMs IDLE, decouple_ack=0, count=0.

Source files
------------

// File: rtl/axil_pr_pkg.sv
// Shared response codes, the local error read pattern and the state types
// used by the north PR AXI-Lite decouple guard.
package axil_pr_pkg;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;
  localparam logic [31:0] DECOUPLE_RDATA = 32'hDEC0_DEAD;

  typedef enum logic [2:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP, W_DRAIN} wr_state_t;
  typedef enum logic [2:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP, R_DRAIN} rd_state_t;

endpackage

// File: rtl/axil_pr_timeout_ctr.sv
// Per-direction response timer: cleared by load, advances while enabled and
// flags expire once TIMEOUT_CYCLES-1 enabled cycles have elapsed.
module axil_pr_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TC = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) cnt <= '0;
    else if (en && (cnt != TC)) cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == TC);

endmodule

// File: rtl/axil_pr_decouple_guard.sv
// AXI-Lite guard in front of the north PR region: forwards while coupled,
// answers SLVERR locally while decoupled or when the region stops responding.
//
// state   | meaning
// --------+---------------------------------------------------------------
// x_IDLE  | accepting an upstream request (AW and W independently for writes)
// x_ISSUE | presenting the captured request downstream, timer running
// x_WAIT  | waiting for the downstream response, timer running
// x_RESP  | holding the upstream response until it is taken
// x_DRAIN | swallowing a late downstream response after a timeout
module axil_pr_decouple_guard
  import axil_pr_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                s_axil_awvalid,
  output logic                s_axil_awready,
  input  logic [ADDR_W-1:0]   s_axil_awaddr,
  input  logic [2:0]          s_axil_awprot,
  input  logic                s_axil_wvalid,
  output logic                s_axil_wready,
  input  logic [DATA_W-1:0]   s_axil_wdata,
  input  logic [DATA_W/8-1:0] s_axil_wstrb,
  output logic                s_axil_bvalid,
  input  logic                s_axil_bready,
  output logic [1:0]          s_axil_bresp,
  input  logic                s_axil_arvalid,
  output logic                s_axil_arready,
  input  logic [ADDR_W-1:0]   s_axil_araddr,
  input  logic [2:0]          s_axil_arprot,
  output logic                s_axil_rvalid,
  input  logic                s_axil_rready,
  output logic [DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]          s_axil_rresp,
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  input  logic [1:0]          m_axil_bresp,
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  input  logic                decouple_req,
  output logic                decouple_ack,
  output logic                timeout_pulse,
  output logic [CNT_W-1:0]    timeout_count
);

  localparam int SW = DATA_W / 8;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic              aw_held, w_held, aw_hs, w_hs, wr_start;
  logic              m_awvalid_q, m_wvalid_q, aw_left, w_left;
  logic              wr_bready, wr_load, wr_en, wr_expire, wr_timeout, wr_orphan;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [2:0]        awprot_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     wstrb_q;

  logic              ar_hs, rd_start, m_arvalid_q, ar_left;
  logic              rd_rready, rd_load, rd_en, rd_expire, rd_timeout, rd_orphan;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arprot_q;

  logic              decouple_q, both_idle, timeout_pulse_q;
  logic [CNT_W-1:0]  timeout_cnt_q;
  logic [1:0]        to_inc;
  logic [CNT_W:0]    to_sum;

  assign m_axil_awvalid = m_awvalid_q && !decouple_q;
  assign m_axil_wvalid  = m_wvalid_q && !decouple_q;
  assign m_axil_arvalid = m_arvalid_q && !decouple_q;
  assign m_axil_bready  = wr_bready && !decouple_q;
  assign m_axil_rready  = rd_rready && !decouple_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = awprot_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  assign aw_left = m_awvalid_q && !(m_axil_awvalid && m_axil_awready);
  assign w_left  = m_wvalid_q && !(m_axil_wvalid && m_axil_wready);
  assign ar_left = m_arvalid_q && !(m_axil_arvalid && m_axil_arready);

  always_comb begin
    wr_next        = wr_state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    wr_bready      = 1'b0;
    wr_load        = 1'b0;
    wr_en          = 1'b0;
    wr_timeout     = 1'b0;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    wr_start       = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_axil_awready = !aw_held;
        s_axil_wready  = !w_held;
        aw_hs          = s_axil_awvalid && !aw_held;
        w_hs           = s_axil_wvalid && !w_held;
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          wr_start = 1'b1;
          if (decouple_q) wr_next = W_RESP;
          else begin
            wr_next = W_ISSUE;
            wr_load = 1'b1;
          end
        end
      end
      W_ISSUE: begin
        wr_en = 1'b1;
        if (wr_expire) begin
          wr_timeout = 1'b1;
          wr_next    = W_RESP;
        end else if (!aw_left && !w_left) wr_next = W_WAIT;
      end
      W_WAIT: begin
        wr_en     = 1'b1;
        wr_bready = 1'b1;
        if (m_axil_bvalid) wr_next = W_RESP;
        else if (wr_expire) begin
          wr_timeout = 1'b1;
          wr_next    = W_RESP;
        end
      end
      W_RESP: begin
        s_axil_bvalid = 1'b1;
        if (s_axil_bready) wr_next = wr_orphan ? W_DRAIN : W_IDLE;
      end
      W_DRAIN: begin
        wr_bready = 1'b1;
        if (m_axil_bvalid || decouple_q) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_state    <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      bresp_q     <= RESP_OKAY;
      wr_orphan   <= 1'b0;
      awaddr_q    <= '0;
      awprot_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axil_awaddr;
        awprot_q <= s_axil_awprot;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (m_axil_awvalid && m_axil_awready) m_awvalid_q <= 1'b0;
      if (m_axil_wvalid && m_axil_wready) m_wvalid_q <= 1'b0;
      if (decouple_q) begin
        m_awvalid_q <= 1'b0;
        m_wvalid_q  <= 1'b0;
      end
      if (wr_start) begin
        aw_held   <= 1'b0;
        w_held    <= 1'b0;
        wr_orphan <= 1'b0;
        if (decouple_q) bresp_q <= RESP_SLVERR;
        else begin
          m_awvalid_q <= 1'b1;
          m_wvalid_q  <= 1'b1;
        end
      end
      if ((wr_state == W_WAIT) && m_axil_bvalid) bresp_q <= m_axil_bresp;
      if (wr_timeout) begin
        bresp_q   <= RESP_SLVERR;
        wr_orphan <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_next        = rd_state;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    rd_rready      = 1'b0;
    rd_load        = 1'b0;
    rd_en          = 1'b0;
    rd_timeout     = 1'b0;
    ar_hs          = 1'b0;
    rd_start       = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_axil_arready = 1'b1;
        ar_hs          = s_axil_arvalid;
        if (ar_hs) begin
          rd_start = 1'b1;
          if (decouple_q) rd_next = R_RESP;
          else begin
            rd_next = R_ISSUE;
            rd_load = 1'b1;
          end
        end
      end
      R_ISSUE: begin
        rd_en = 1'b1;
        if (rd_expire) begin
          rd_timeout = 1'b1;
          rd_next    = R_RESP;
        end else if (!ar_left) rd_next = R_WAIT;
      end
      R_WAIT: begin
        rd_en     = 1'b1;
        rd_rready = 1'b1;
        if (m_axil_rvalid) rd_next = R_RESP;
        else if (rd_expire) begin
          rd_timeout = 1'b1;
          rd_next    = R_RESP;
        end
      end
      R_RESP: begin
        s_axil_rvalid = 1'b1;
        if (s_axil_rready) rd_next = rd_orphan ? R_DRAIN : R_IDLE;
      end
      R_DRAIN: begin
        rd_rready = 1'b1;
        if (m_axil_rvalid || decouple_q) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_state    <= R_IDLE;
      m_arvalid_q <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      rd_orphan   <= 1'b0;
      araddr_q    <= '0;
      arprot_q    <= '0;
    end else begin
      rd_state <= rd_next;
      if (m_axil_arvalid && m_axil_arready) m_arvalid_q <= 1'b0;
      if (decouple_q) m_arvalid_q <= 1'b0;
      if (rd_start) begin
        araddr_q  <= s_axil_araddr;
        arprot_q  <= s_axil_arprot;
        rd_orphan <= 1'b0;
        if (decouple_q) begin
          rdata_q <= DATA_W'(DECOUPLE_RDATA);
          rresp_q <= RESP_SLVERR;
        end else m_arvalid_q <= 1'b1;
      end
      if ((rd_state == R_WAIT) && m_axil_rvalid) begin
        rdata_q <= m_axil_rdata;
        rresp_q <= m_axil_rresp;
      end
      if (rd_timeout) begin
        rdata_q   <= DATA_W'(DECOUPLE_RDATA);
        rresp_q   <= RESP_SLVERR;
        rd_orphan <= 1'b1;
      end
    end
  end

  axil_pr_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .load   (wr_load),
    .en     (wr_en),
    .expire (wr_expire)
  );

  axil_pr_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .load   (rd_load),
    .en     (rd_en),
    .expire (rd_expire)
  );

  // A request accepted in the same cycle must not see isolation switch under it.
  assign both_idle = (wr_state == W_IDLE) && (rd_state == R_IDLE) && !wr_start && !rd_start;
  assign to_inc    = {1'b0, wr_timeout} + {1'b0, rd_timeout};
  assign to_sum    = {1'b0, timeout_cnt_q} + {{(CNT_W-1){1'b0}}, to_inc};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      decouple_q      <= 1'b0;
      timeout_pulse_q <= 1'b0;
      timeout_cnt_q   <= '0;
    end else begin
      if (both_idle) decouple_q <= decouple_req;
      timeout_pulse_q <= wr_timeout || rd_timeout;
      timeout_cnt_q   <= to_sum[CNT_W] ? '1 : to_sum[CNT_W-1:0];
    end
  end

  assign decouple_ack  = decouple_q;
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_count = timeout_cnt_q;

endmodule

// File: tb/tb_axil_pr_decouple_guard.sv
// Directed bench for the PR decouple guard; expected upstream responses are
// queued when a request is driven and compared when the DUT answers.
module tb_axil_pr_decouple_guard;

  localparam int TO    = 16;
  // Narrow counter so saturation is reachable within a short run.
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic        sys_clk, sys_rst;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic [2:0]  s_axil_awprot, s_axil_arprot;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        decouple_req, decouple_ack, timeout_pulse;
  logic [CNT_W-1:0] timeout_count;

  int checks = 0;
  int errors = 0;
  logic [1:0] bq[$];
  r_exp_t     rq[$];

  axil_pr_decouple_guard #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .decouple_req(decouple_req), .decouple_ack(decouple_ack),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic collect_b(input string tag, input int budget, output int n);
    logic [1:0] e;
    n = 0;
    while (!s_axil_bvalid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_bvalid"}, 64'(s_axil_bvalid), 64'(1));
    check({tag, "_bq"}, 64'(bq.size() > 0), 64'(1));
    if (s_axil_bvalid && bq.size() > 0) begin
      e = bq.pop_front();
      check({tag, "_bresp"}, 64'(s_axil_bresp), 64'(e));
    end
  endtask

  task automatic collect_r(input string tag, input int budget, output int n);
    r_exp_t e;
    n = 0;
    while (!s_axil_rvalid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_rvalid"}, 64'(s_axil_rvalid), 64'(1));
    check({tag, "_rq"}, 64'(rq.size() > 0), 64'(1));
    if (s_axil_rvalid && rq.size() > 0) begin
      e = rq.pop_front();
      check({tag, "_rdata"}, 64'(s_axil_rdata), 64'(e.data));
      check({tag, "_rresp"}, 64'(s_axil_rresp), 64'(e.resp));
    end
  endtask

  // Issue with a silent downstream slave, expect local SLVERR after TO cycles,
  // then deliver a late downstream response that must be swallowed.
  task automatic run_timeout(input string tag, input bit do_wr, input bit do_rd,
                             input logic [CNT_W-1:0] exp_cnt, input int late);
    int n;
    logic seen;
    if (do_wr) begin
      bq.push_back(2'b10);
      s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h70;
      s_axil_wvalid  = 1'b1; s_axil_wdata  = 32'h1111_2222;
    end
    if (do_rd) begin
      rq.push_back('{data: 32'hDEC0_DEAD, resp: 2'b10});
      s_axil_arvalid = 1'b1; s_axil_araddr = 32'h30;
    end
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    n = 0;
    while (!(s_axil_bvalid || s_axil_rvalid) && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(TO));
    if (do_wr) collect_b(tag, 0, n);
    if (do_rd) collect_r(tag, 0, n);
    check({tag, "_pulse"}, 64'(timeout_pulse), 64'(1));
    check({tag, "_count"}, 64'(timeout_count), 64'(exp_cnt));
    tick();
    check({tag, "_pulse_off"}, 64'(timeout_pulse), 64'(0));
    repeat (late) tick();
    check({tag, "_drain_ready"}, 64'({m_axil_bready, m_axil_rready}), 64'({do_wr, do_rd}));
    m_axil_bvalid = do_wr; m_axil_bresp = 2'b00;
    m_axil_rvalid = do_rd; m_axil_rdata = 32'hBAD0_BAD0; m_axil_rresp = 2'b00;
    tick();
    m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      seen = seen | s_axil_bvalid | s_axil_rvalid;
      tick();
    end
    check({tag, "_late_fwd"}, 64'(seen), 64'(0));
  endtask

  initial begin
    int n;
    sys_rst = 1'b1;
    s_axil_awvalid = 0; s_axil_awaddr = 0; s_axil_awprot = 0;
    s_axil_wvalid = 0; s_axil_wdata = 0; s_axil_wstrb = 4'hF;
    s_axil_bready = 1; s_axil_arvalid = 0; s_axil_araddr = 0; s_axil_arprot = 0;
    s_axil_rready = 1;
    m_axil_awready = 1; m_axil_wready = 1; m_axil_arready = 1;
    m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
    decouple_req = 0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();

    check("rst_valids", 64'({s_axil_bvalid, s_axil_rvalid, m_axil_awvalid, m_axil_wvalid,
                             m_axil_arvalid, m_axil_bready, m_axil_rready}), 64'(0));
    check("rst_ack_cnt", 64'({decouple_ack, timeout_count}), 64'(0));
    check("rst_idle_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
    check("rst_awaddr", 64'(m_axil_awaddr), 64'(0));

    // coupled write, OKAY after 5 cycles
    bq.push_back(2'b00);
    s_axil_awvalid = 1; s_axil_awaddr = 32'h10; s_axil_wvalid = 1; s_axil_wdata = 32'hCAFE_F00D;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    check("wr_m_valid", 64'({m_axil_awvalid, m_axil_wvalid}), 64'(2'b11));
    check("wr_m_awaddr", 64'(m_axil_awaddr), 64'(32'h10));
    check("wr_m_wdata", 64'(m_axil_wdata), 64'(32'hCAFE_F00D));
    tick();
    check("wr_wait", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'(3'b001));
    repeat (4) tick();
    m_axil_bvalid = 1; m_axil_bresp = 2'b00;
    tick();
    m_axil_bvalid = 0;
    collect_b("wr1", 5, n);
    check("wr1_lat", 64'(n), 64'(0));
    tick();
    check("wr1_count", 64'(timeout_count), 64'(0));

    // coupled read
    rq.push_back('{data: 32'h1234_5678, resp: 2'b00});
    s_axil_arvalid = 1; s_axil_araddr = 32'h20;
    tick();
    s_axil_arvalid = 0;
    check("rd_m_arvalid", 64'(m_axil_arvalid), 64'(1));
    check("rd_m_araddr", 64'(m_axil_araddr), 64'(32'h20));
    tick();
    check("rd_m_rready", 64'(m_axil_rready), 64'(1));
    m_axil_rvalid = 1; m_axil_rdata = 32'h1234_5678; m_axil_rresp = 2'b00;
    tick();
    m_axil_rvalid = 0;
    collect_r("rd1", 5, n);
    check("rd1_lat", 64'(n), 64'(0));
    tick();

    // silent slave read, late response 30 cycles later
    run_timeout("to_rd", 1'b0, 1'b1, CNT_W'(1), 30);

    // decouple requested while a write waits downstream
    bq.push_back(2'b00);
    s_axil_awvalid = 1; s_axil_awaddr = 32'h40; s_axil_wvalid = 1; s_axil_wdata = 32'h5555_AAAA;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    tick();
    decouple_req = 1;
    repeat (3) tick();
    check("dec_ack_held", 64'(decouple_ack), 64'(0));
    m_axil_bvalid = 1; m_axil_bresp = 2'b00;
    tick();
    m_axil_bvalid = 0;
    collect_b("dec_wr", 5, n);
    n = 0;
    while (!decouple_ack && n < 10) begin
      tick();
      n++;
    end
    check("dec_ack_rise", 64'(decouple_ack), 64'(1));
    bq.push_back(2'b10);
    s_axil_awvalid = 1; s_axil_awaddr = 32'h50; s_axil_wvalid = 1; s_axil_wdata = 32'h0;
    tick();
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    check("dec_wr_no_m", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'(0));
    collect_b("dec_wr2", 2, n);
    check("dec_wr2_lat", 64'(n <= 1), 64'(1));
    tick();
    rq.push_back('{data: 32'hDEC0_DEAD, resp: 2'b10});
    s_axil_arvalid = 1; s_axil_araddr = 32'h54;
    tick();
    s_axil_arvalid = 0;
    check("dec_rd_no_m", 64'({m_axil_arvalid, m_axil_rready}), 64'(0));
    collect_r("dec_rd", 2, n);
    tick();
    check("dec_count", 64'(timeout_count), 64'(1));
    decouple_req = 0;
    n = 0;
    while (decouple_ack && n < 10) begin
      tick();
      n++;
    end
    check("dec_ack_fall", 64'(decouple_ack), 64'(0));

    // simultaneous timeouts up to and past saturation
    run_timeout("to_dual1", 1'b1, 1'b1, CNT_W'(3), 2);
    run_timeout("to_dual2", 1'b1, 1'b1, CNT_W'(5), 2);
    run_timeout("to_single", 1'b0, 1'b1, CNT_MAX - 1'b1, 2);
    run_timeout("to_sat", 1'b1, 1'b1, CNT_MAX, 2);
    run_timeout("to_sat_hold", 1'b1, 1'b1, CNT_MAX, 2);

    // reset in the middle of a read wait
    s_axil_arvalid = 1; s_axil_araddr = 32'h60;
    tick();
    s_axil_arvalid = 0;
    tick();
    check("mid_rd_wait", 64'(m_axil_rready), 64'(1));
    sys_rst = 1;
    tick();
    sys_rst = 0;
    check("mrst_valids", 64'({s_axil_bvalid, s_axil_rvalid, m_axil_awvalid, m_axil_wvalid,
                              m_axil_arvalid, m_axil_bready, m_axil_rready}), 64'(0));
    check("mrst_idle", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
    check("mrst_ack_cnt", 64'({decouple_ack, timeout_count}), 64'(0));
    n = 0;
    repeat (TO + 4) begin
      n = n + int'(s_axil_rvalid);
      tick();
    end
    check("mrst_no_resp", 64'(n), 64'(0));
    check("sb_empty", 64'(bq.size() + rq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
